// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out framing controller: counts gated serial bits into frames
// of programmable length, right-aligns each frame into a one-word valid/ready buffer.
module sipo_frame_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [CNT_WIDTH-1:0]  i_frame_len,
  input  logic                  i_dir,
  input  logic                  i_din,
  input  logic                  i_din_valid,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_dout_valid,
  input  logic                  i_dout_ready,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_bit_cnt,
  output logic                  o_overflow
);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;

  localparam logic [CNT_WIDTH-1:0] DW_CNT = CNT_WIDTH'(DATA_WIDTH);

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_sreg, w_sreg_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic [CNT_WIDTH-1:0]  r_len, w_len_nxt;
  logic                  r_dir, w_dir_nxt;
  logic [DATA_WIDTH-1:0] r_dout, w_dout_nxt;
  logic                  r_dout_valid, w_dout_valid_nxt;
  logic                  r_ovf, w_ovf_nxt;

  logic                  w_drain;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [CNT_WIDTH-1:0]  w_cnt_inc;
  logic [CNT_WIDTH-1:0]  w_len_eff;

  // Left mode keeps the newest len bits at the bottom; right mode has them at the top.
  function automatic logic [DATA_WIDTH-1:0] f_align(input logic [DATA_WIDTH-1:0] s,
                                                   input logic [CNT_WIDTH-1:0]  len,
                                                   input logic                  rdir);
    logic [DATA_WIDTH-1:0] mask;
    mask = ~({DATA_WIDTH{1'b1}} << len);
    if (rdir) f_align = s >> (DATA_WIDTH - int'(len));
    else      f_align = s & mask;
  endfunction

  assign w_drain   = r_dout_valid & i_dout_ready;
  assign w_shifted = r_dir ? {i_din, r_sreg[DATA_WIDTH-1:1]} : {r_sreg[DATA_WIDTH-2:0], i_din};
  assign w_cnt_inc = r_cnt + CNT_WIDTH'(1);
  assign w_len_eff = (i_frame_len == '0 || i_frame_len > DW_CNT) ? DW_CNT : i_frame_len;

  always_comb begin
    w_state_nxt      = r_state;
    w_sreg_nxt       = r_sreg;
    w_cnt_nxt        = r_cnt;
    w_len_nxt        = r_len;
    w_dir_nxt        = r_dir;
    w_dout_nxt       = r_dout;
    w_dout_valid_nxt = r_dout_valid & ~w_drain;
    w_ovf_nxt        = r_ovf;
    unique case (r_state)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          w_state_nxt = S_SHIFT;
          w_len_nxt   = w_len_eff;
          w_dir_nxt   = i_dir;
          w_sreg_nxt  = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      S_SHIFT: begin
        if (i_stop) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (i_din_valid) begin
          w_sreg_nxt = w_shifted;
          w_cnt_nxt  = w_cnt_inc;
          if (w_cnt_inc == r_len) begin
            if (!r_dout_valid || w_drain) begin
              w_dout_nxt       = f_align(w_shifted, r_len, r_dir);
              w_dout_valid_nxt = 1'b1;
              w_cnt_nxt        = '0;
            end else begin
              w_state_nxt = S_HOLD;
            end
          end
        end
      end
      S_HOLD: begin
        if (i_stop) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          if (i_din_valid) w_ovf_nxt = 1'b1;
          if (w_drain) begin
            w_dout_nxt       = f_align(r_sreg, r_len, r_dir);
            w_dout_valid_nxt = 1'b1;
            w_cnt_nxt        = '0;
            w_state_nxt      = S_SHIFT;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sreg       <= '0;
      r_cnt        <= '0;
      r_len        <= '0;
      r_dir        <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sreg       <= w_sreg_nxt;
      r_cnt        <= w_cnt_nxt;
      r_len        <= w_len_nxt;
      r_dir        <= w_dir_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_ovf        <= w_ovf_nxt;
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_busy       = (r_state != S_IDLE);
  assign o_bit_cnt    = r_cnt;
  assign o_overflow   = r_ovf;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl (DATA_WIDTH=8): vector table, directed corner sequences,
// then randomized traffic against a queue-based frame model.
module tb_sipo_frame_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, dir, din, din_valid, dout_ready;
  logic [3:0] frame_len;
  logic [7:0] dout;
  logic       dout_valid, busy, overflow;
  logic [3:0] bit_cnt;

  int total = 0;
  int bad   = 0;

  sipo_frame_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_stop(stop), .i_frame_len(frame_len),
    .i_dir(dir), .i_din(din), .i_din_valid(din_valid), .o_dout(dout),
    .o_dout_valid(dout_valid), .i_dout_ready(dout_ready), .o_busy(busy),
    .o_bit_cnt(bit_cnt), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       start, stop;
    logic [3:0] len;
    logic       dir, din, dvld, rdy;
    logic [7:0] e_dout;
    logic       e_dv, e_busy;
    logic [3:0] e_cnt;
    logic       e_ovf;
  } vec_t;
  vec_t tbl[$];
  logic [7:0] t_dout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic [7:0] e_dout, input logic e_dv,
                           input logic e_busy, input logic [3:0] e_cnt, input logic e_ovf);
    chk({nm, ".dout"},       32'(dout),       32'(e_dout));
    chk({nm, ".dout_valid"}, 32'(dout_valid), 32'(e_dv));
    chk({nm, ".busy"},       32'(busy),       32'(e_busy));
    chk({nm, ".bit_cnt"},    32'(bit_cnt),    32'(e_cnt));
    chk({nm, ".overflow"},   32'(overflow),   32'(e_ovf));
  endtask

  task automatic drive(input logic s, input logic p, input logic [3:0] l, input logic d,
                       input logic b, input logic v, input logic r);
    start = s; stop = p; frame_len = l; dir = d; din = b; din_valid = v; dout_ready = r;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic stepc(input string nm, input logic s, input logic p, input logic [3:0] l,
                       input logic d, input logic b, input logic v, input logic r,
                       input logic [7:0] e_dout, input logic e_dv, input logic e_busy,
                       input logic [3:0] e_cnt, input logic e_ovf);
    drive(s, p, l, d, b, v, r);
    tick();
    check_all(nm, e_dout, e_dv, e_busy, e_cnt, e_ovf);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  // seq bit i is the i-th serial bit sent
  task automatic push_frame(input logic [3:0] len, input logic d, input logic [7:0] seq,
                            input int n, input logic [7:0] exp);
    vec_t v;
    v.start = 1; v.stop = 0; v.len = len; v.dir = d; v.din = 0; v.dvld = 0; v.rdy = 1;
    v.e_dout = t_dout; v.e_dv = 0; v.e_busy = 1; v.e_cnt = 0; v.e_ovf = 0;
    tbl.push_back(v);
    for (int i = 0; i < n; i++) begin
      v.start = 0; v.din = seq[i]; v.dvld = 1;
      if (i == n - 1) begin
        t_dout = exp; v.e_dout = exp; v.e_dv = 1; v.e_cnt = 0;
      end else begin
        v.e_cnt = 4'(i + 1);
      end
      tbl.push_back(v);
    end
    v.stop = 1; v.dvld = 0; v.din = 0; v.e_dv = 0; v.e_busy = 0; v.e_cnt = 0;
    tbl.push_back(v);
  endtask

  // behavioural model: the current frame is a queue of bits, the word is built from it
  bit         m_active, m_held, m_dv, m_ovf, m_dir;
  int         m_L;
  logic [7:0] m_dout;
  bit         m_bits[$];

  function automatic logic [7:0] m_word();
    logic [7:0] w = 8'h00;
    for (int i = 0; i < m_bits.size(); i++)
      if (m_dir) w[i] = m_bits[i];
      else       w[m_L - 1 - i] = m_bits[i];
    return w;
  endfunction

  task automatic m_reset();
    m_active = 0; m_held = 0; m_dv = 0; m_ovf = 0; m_dir = 0; m_L = 8; m_dout = 0;
    m_bits.delete();
  endtask

  task automatic m_step(input logic s, input logic p, input logic [3:0] l, input logic d,
                        input logic b, input logic v, input logic r);
    bit drain;
    drain = m_dv && r;
    if (drain) m_dv = 0;
    if (!m_active) begin
      if (s && !p) begin
        m_active = 1; m_held = 0; m_dir = d; m_ovf = 0;
        m_L = (l == 0 || l > 8) ? 8 : int'(l);
        m_bits.delete();
      end
    end else if (p) begin
      m_active = 0; m_held = 0; m_bits.delete();
    end else if (m_held) begin
      if (v) m_ovf = 1;
      if (drain) begin
        m_dout = m_word(); m_dv = 1; m_held = 0; m_bits.delete();
      end
    end else if (v) begin
      m_bits.push_back(b);
      if (m_bits.size() == m_L) begin
        if (!m_dv) begin
          m_dout = m_word(); m_dv = 1; m_bits.delete();
        end else begin
          m_held = 1;
        end
      end
    end
  endtask

  logic [7:0] seq;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick(); tick();
    check_all("reset", 8'h00, 0, 0, 4'd0, 0);
    rst = 1'b0;

    t_dout = 8'h00;
    push_frame(4'd8, 0, 8'h4D, 8, 8'hB2);
    push_frame(4'd8, 1, 8'h4D, 8, 8'h4D);
    push_frame(4'd4, 0, 8'h0B, 4, 8'h0D);
    push_frame(4'd4, 1, 8'h0B, 4, 8'h0B);
    push_frame(4'd0, 0, 8'h4D, 8, 8'hB2);
    push_frame(4'd9, 1, 8'h4D, 8, 8'h4D);
    for (int i = 0; i < tbl.size(); i++)
      stepc($sformatf("tbl%0d", i), tbl[i].start, tbl[i].stop, tbl[i].len, tbl[i].dir,
            tbl[i].din, tbl[i].dvld, tbl[i].rdy, tbl[i].e_dout, tbl[i].e_dv,
            tbl[i].e_busy, tbl[i].e_cnt, tbl[i].e_ovf);

    // back-pressure: second frame parks in HOLD, extra bit overflows
    do_reset();
    stepc("bp_start", 1, 0, 4'd4, 0, 0, 0, 0, 8'h00, 0, 1, 4'd0, 0);
    seq = 8'h5B;  // 1,1,0,1 then 1,0,1,0
    for (int i = 0; i < 8; i++)
      stepc($sformatf("bp_bit%0d", i), 0, 0, 4'd4, 0, seq[i], 1, 0,
            (i >= 3) ? 8'h0D : 8'h00, (i >= 3), 1, (i == 7) ? 4'd4 : 4'((i + 1) % 4), 0);
    stepc("bp_ovf", 0, 0, 4'd4, 0, 1, 1, 0, 8'h0D, 1, 1, 4'd4, 1);
    stepc("bp_release", 0, 0, 4'd4, 0, 1, 1, 1, 8'h0A, 1, 1, 4'd0, 1);
    stepc("bp_drain", 0, 0, 4'd4, 0, 0, 0, 1, 8'h0A, 0, 1, 4'd0, 1);
    stepc("bp_stop", 0, 1, 4'd4, 0, 0, 0, 1, 8'h0A, 0, 0, 4'd0, 1);
    stepc("bp_restart", 1, 0, 4'd4, 0, 0, 0, 1, 8'h0A, 0, 1, 4'd0, 0);

    // single-bit frames
    do_reset();
    stepc("l1_start", 1, 0, 4'd1, 0, 0, 0, 1, 8'h00, 0, 1, 4'd0, 0);
    stepc("l1_bit1", 0, 0, 4'd1, 0, 1, 1, 1, 8'h01, 1, 1, 4'd0, 0);
    stepc("l1_bit0", 0, 0, 4'd1, 0, 0, 1, 1, 8'h00, 1, 1, 4'd0, 0);
    stepc("l1_idle", 0, 0, 4'd1, 0, 0, 0, 1, 8'h00, 0, 1, 4'd0, 0);

    // stop with a pending frame, start&stop in IDLE, din_valid coincident with start
    do_reset();
    stepc("sp_start", 1, 0, 4'd8, 0, 0, 0, 0, 8'h00, 0, 1, 4'd0, 0);
    seq = 8'h4D;
    for (int i = 0; i < 8; i++)
      stepc($sformatf("sp_bit%0d", i), 0, 0, 4'd8, 0, seq[i], 1, 0,
            (i == 7) ? 8'hB2 : 8'h00, (i == 7), 1, (i == 7) ? 4'd0 : 4'(i + 1), 0);
    for (int i = 0; i < 3; i++)
      stepc($sformatf("sp_part%0d", i), 0, 0, 4'd8, 0, 1, 1, 0, 8'hB2, 1, 1, 4'(i + 1), 0);
    stepc("sp_stop", 0, 1, 4'd8, 0, 0, 0, 0, 8'hB2, 1, 0, 4'd0, 0);
    stepc("sp_keep", 0, 0, 4'd8, 0, 0, 0, 0, 8'hB2, 1, 0, 4'd0, 0);
    stepc("sp_drain", 0, 0, 4'd8, 0, 0, 0, 1, 8'hB2, 0, 0, 4'd0, 0);
    stepc("ss_idle", 1, 1, 4'd8, 0, 1, 1, 1, 8'hB2, 0, 0, 4'd0, 0);
    stepc("st_dvld", 1, 0, 4'd8, 0, 1, 1, 1, 8'hB2, 0, 1, 4'd0, 0);
    stepc("st_first", 0, 0, 4'd8, 0, 1, 1, 1, 8'hB2, 0, 1, 4'd1, 0);

    // asynchronous reset mid-frame with a pending word
    do_reset();
    stepc("ar_start", 1, 0, 4'd8, 0, 0, 0, 0, 8'h00, 0, 1, 4'd0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 4'd8, 0, 1, 1, 0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 4'd8, 0, 0, 1, 0);
      tick();
    end
    check_all("ar_before", 8'hFF, 1, 1, 4'd5, 0);
    #2 rst = 1'b1;
    #1 check_all("ar_async", 8'h00, 0, 0, 4'd0, 0);
    tick();
    rst = 1'b0;

    // randomized traffic against the model
    do_reset();
    m_reset();
    for (int c = 0; c < 4000; c++) begin
      logic s, p, d, b, v, r;
      logic [3:0] l;
      s = ($urandom_range(3) == 0);
      p = ($urandom_range(60) == 0);
      l = 4'($urandom_range(15));
      d = 1'($urandom_range(1));
      b = 1'($urandom_range(1));
      v = ($urandom_range(3) != 0);
      r = (c < 2000) ? 1'($urandom_range(1)) : ($urandom_range(9) != 0);
      m_step(s, p, l, d, b, v, r);
      drive(s, p, l, d, b, v, r);
      tick();
      check_all($sformatf("rand%0d", c), m_dout, m_dv, m_active, 4'(m_bits.size()), m_ovf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Framing controller for the serial-in/parallel-out shift path. It accepts a gated serial bit stream, counts bits into frames of programmable length, and shifts left (MSB first) or right (LSB first). Each completed frame is right-aligned into a one-word output buffer with a valid/ready handshake. It sits between a serial source and any word-wide consumer, and replaces free-running shift registers whose framing is left to downstream logic.

## Interface
- DATA_WIDTH, 32, shift register and output word width (≥2)
- CNT_WIDTH, 6, width of frame_len and bit_cnt; must represent DATA_WIDTH
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin framing; accepted only in IDLE
- stop  in  1  abandon framing, return to IDLE
- frame_len  in  CNT_WIDTH  bits per frame, sampled on accepted start
- dir  in  1  0 = left shift (MSB first), 1 = right shift (LSB first); sampled on accepted start
- din  in  1  serial data bit
- din_valid  in  1  din qualifier
- dout  out  DATA_WIDTH  assembled frame, right-aligned, upper bits zero
- dout_valid  out  1  dout holds an unconsumed frame
- dout_ready  in  1  consumer accepts dout
- busy  out  1  state ≠ IDLE
- bit_cnt  out  CNT_WIDTH  bits accepted in current frame
- overflow  out  1  sticky: a valid bit was dropped

## Operation
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - din_valid is ignored.
  - start & !stop → SHIFT. Latch dir and effective length (frame_len of 0 or >DATA_WIDTH → DATA_WIDTH). Clear the shift register and bit_cnt, clear overflow.
  - stop has priority over start.
- SHIFT, on each din_valid:
  - Left mode: sreg ← {sreg[DATA_WIDTH-2:0], din}.
  - Right mode: sreg ← {din, sreg[DATA_WIDTH-1:1]}.
  - bit_cnt increments.
- Frame completion happens on the bit that makes the count equal to the length L:
  - Aligned word, left mode: the L shifted bits occupy [L-1:0]. The first bit lands at L-1.
  - Aligned word, right mode: the register is shifted right by DATA_WIDTH-L. The first bit lands at bit 0 and the last at L-1.
  - Bits above L-1 are zero.
  - If the buffer is empty, or is draining this cycle (dout_valid & dout_ready): dout ← aligned word, dout_valid ← 1, bit_cnt ← 0, stay in SHIFT. Framing is continuous.
  - Otherwise the word stays in sreg → HOLD.
- HOLD:
  - din_valid drops the bit and sets overflow. Sreg and bit_cnt are unchanged.
  - On a dout handshake, dout ← aligned held word, dout_valid stays 1, bit_cnt ← 0 → SHIFT. A din_valid in that same cycle is still dropped (overflow set).
- stop in SHIFT or HOLD → IDLE. The partial or held frame is discarded. The output buffer and its dout_valid are unaffected.
- start in SHIFT or HOLD is ignored.
- Output buffer:
  - dout_valid clears on a handshake unless reloaded in the same cycle.
  - dout is stable while dout_valid is 1 and no handshake occurs.
- overflow clears only on rst or an accepted start.

## Timing
- Reset value: all outputs 0, state IDLE, sreg 0.
- Start latency: the first bit is accepted on the edge after the start edge. din_valid coincident with start is ignored.
- Frame latency: dout_valid is high in the cycle after the edge that accepts bit L.
- Back-to-back frames: with dout_ready held at 1, one frame is produced every L valid bits with no bubble. Drain and reload in the same cycle are supported.
- Handshake: transfer occurs on a rising edge with dout_valid & dout_ready. dout_ready is ignored while dout_valid is 0.
- L = 1 is legal: every valid bit produces a frame.
- rst mid-frame or in HOLD immediately clears all state and outputs, asynchronously.

## Test plan
Bench uses DATA_WIDTH=8, dout_ready=1 unless stated.
- Left, L=8, bits 1,0,1,1,0,0,1,0 → dout=8'hB2, dout_valid one cycle after the 8th bit, bit_cnt back to 0.
- Right, L=8, same bits → dout=8'h4D. Then left L=4, bits 1,1,0,1 → 8'h0D. Right L=4, bits 1,1,0,1 → 8'h0B.
- Back-pressure, left L=4:
  - Hold dout_ready=0 and send 8 bits → 8'h0D presented, second frame in HOLD, busy=1.
  - Send 1 more bit → overflow=1.
  - Raise dout_ready for 1 cycle → second frame on dout, dout_valid still 1.
- frame_len=0 and frame_len=9 both frame at 8 bits. L=1 with bits 1,0 → dout 8'h01 then 8'h00 on consecutive cycles.
- stop after 3 bits with a previous frame pending → IDLE, bit_cnt=0, pending dout/dout_valid kept until handshake. start & stop together in IDLE → stays IDLE.
- Assert rst after 5 bits and with dout_valid=1 → dout=0, dout_valid=0, overflow=0, busy=0, bit_cnt=0 without waiting for a clock edge.
